lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron. It sits directly downstream of the synapse stage and consumes its signed 18-bit current output. Each enabled tick it integrates that current into a membrane potential with exponential leak. On a threshold crossing it emits a one-cycle spike, which is fed back as an s1/s2/s3 input to other synapses, then enters a refractory period.

Parameters:
WIDTH, 18, bit width of synaptic current and membrane potential (signed two's complement)
LEAK_SHIFT, 4, leak term is v >>> LEAK_SHIFT (arithmetic shift)
THRESHOLD, 4096, signed firing threshold; fire when v_next >= THRESHOLD
V_RESET, 0, signed potential loaded on fire and held during refractory
REFRACT_CYCLES, 8, number of enabled ticks spent in refractory; 0 disables refractory
CNT_WIDTH, 16, width of spike counter

Ports:
clock  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high
enable  input  1  integration tick; state advances only when high
i_syn  input  WIDTH  signed synaptic current from upstream synapse
spike  output  1  registered one-cycle fire pulse
v_mem  output  WIDTH  signed membrane potential (register value)
refractory  output  1  high while in REFRACT state
spike_count  output  CNT_WIDTH  saturating count of spikes since reset

Behaviour:
- Reset: takes priority over everything, including simultaneous enable. Loads v_mem=0, spike=0, refractory=0, spike_count=0, state=INTEGRATE, refractory counter=0.
- States: INTEGRATE, REFRACT. The refractory output is high exactly when state=REFRACT.
- Enable low: all state holds and spike=0. A spike pulse never lasts more than one cycle.
- INTEGRATE, enable high:
  - Compute v_next = v + i_syn - (v >>> LEAK_SHIFT) at WIDTH+2 bits.
  - Saturate v_next to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around.
  - The arithmetic shift floors, so 0 <= v < 2^LEAK_SHIFT leaks nothing and v = -1 leaks to 0.
- Fire condition: saturated v_next >= THRESHOLD. Then on the same edge:
  - v_mem <= V_RESET and spike <= 1.
  - spike_count increments, saturating at all-ones.
  - If REFRACT_CYCLES > 0: state <= REFRACT, counter <= REFRACT_CYCLES. Otherwise stay in INTEGRATE.
- No fire: v_mem <= saturated v_next, spike <= 0.
- Latency: spike and reset v_mem are visible the cycle after the enabled edge that crossed threshold.
- REFRACT, enable high:
  - i_syn is ignored, v_mem is held at V_RESET, spike=0, counter decrements.
  - When counter==1 on an enabled edge, state <= INTEGRATE on that edge. Integration resumes on the next enabled tick.
  - Exactly REFRACT_CYCLES enabled ticks are consumed.
- REFRACT, enable low: counter holds.
- Reset mid-refractory: returns to INTEGRATE with counter=0. The next enabled tick integrates normally.
- THRESHOLD above the maximum representable value: the neuron never fires. Saturation still applies.

Test Plan:
1. Reset with enable=1 and i_syn=5000 on the same cycle -> next cycle v_mem=0, spike=0, refractory=0, spike_count=0.
2. Defaults, i_syn=1000 constant, enable=1 from v=0:
   - v_mem goes 1000, 1938, 2817, 3641.
   - The 5th tick (v_next=4414) gives spike=1 for one cycle, v_mem=0, spike_count=1, refractory=1.
3. After test 2, i_syn=131071, enable=1:
   - refractory stays high for 8 enabled ticks, with v_mem=0 and spike=0 throughout.
   - Inserting enable=0 for 3 cycles mid-period extends the period by 3 cycles.
   - The first integrating tick then gives v_mem=THRESHOLD-capped behaviour: fires immediately, spike=1.
4. i_syn=-131072 constant from v=0:
   - v_mem=-131072 after tick 1.
   - Tick 2 computes -253952, which saturates to -131072.
   - v_mem remains -131072 with no wrap and no spike.
5. enable=0 for 10 cycles with i_syn=5000 and v_mem=1938 -> v_mem stays 1938, spike=0, spike_count unchanged.
6. Assert reset during the 4th refractory tick -> next cycle refractory=0 and v_mem=0. The next enabled tick with i_syn=1000 gives v_mem=1000.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates a signed synaptic current into a
// saturating membrane potential with exponential leak, fires a one-cycle spike
// on a threshold crossing, then sits out a refractory period of enabled ticks.
module lif_neuron #(
  parameter int WIDTH          = 18,
  parameter int LEAK_SHIFT     = 4,
  parameter int THRESHOLD      = 4096,
  parameter int V_RESET        = 0,
  parameter int REFRACT_CYCLES = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic signed [WIDTH-1:0]     i_syn,
  output logic                        spike,
  output logic signed [WIDTH-1:0]     v_mem,
  output logic                        refractory,
  output logic        [CNT_WIDTH-1:0] spike_count
);

  typedef enum logic {INTEGRATE, REFRACT} state_t;

  // Refractory counter must hold REFRACT_CYCLES; keep at least one bit when disabled.
  localparam int RC_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic        [RC_W-1:0]    RC_LOAD = RC_W'(REFRACT_CYCLES);
  localparam logic signed [WIDTH-1:0]   V_RST   = WIDTH'(V_RESET);
  // Saturation bounds expressed at the two-bit-wider working width.
  localparam logic signed [WIDTH+1:0]   V_MAX   = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0]   V_MIN   = {3'b111, {(WIDTH-1){1'b0}}};

  state_t                   state, state_nx;
  logic        [RC_W-1:0]   cnt, cnt_nx;
  logic signed [WIDTH-1:0]  leak;
  logic signed [WIDTH+1:0]  sum, sat;
  logic signed [WIDTH-1:0]  v_nx;
  logic                     spike_nx;
  logic [CNT_WIDTH-1:0]     count_nx;
  logic                     fire;

  assign refractory = (state == REFRACT);

  // Integrate-with-leak at WIDTH+2 bits so the sum cannot overflow before clamping.
  always_comb begin
    leak = v_mem >>> LEAK_SHIFT;
    sum  = {{2{v_mem[WIDTH-1]}}, v_mem}
         + {{2{i_syn[WIDTH-1]}}, i_syn}
         - {{2{leak[WIDTH-1]}}, leak};
    if (sum > V_MAX)      sat = V_MAX;
    else if (sum < V_MIN) sat = V_MIN;
    else                  sat = sum;
    // Compare at 32 bits so a threshold beyond the representable range never fires.
    fire = (32'(sat) >= THRESHOLD);
  end

  // Next-state and next-output logic; everything holds while enable is low.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    v_nx     = v_mem;
    spike_nx = 1'b0;
    count_nx = spike_count;
    if (enable) begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            v_nx     = V_RST;
            spike_nx = 1'b1;
            if (spike_count != '1) count_nx = spike_count + CNT_WIDTH'(1);
            if (REFRACT_CYCLES > 0) begin
              state_nx = REFRACT;
              cnt_nx   = RC_LOAD;
            end
          end else begin
            v_nx = sat[WIDTH-1:0];
          end
        end
        REFRACT: begin
          v_nx = V_RST;
          if (cnt <= RC_W'(1)) begin
            state_nx = INTEGRATE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - RC_W'(1);
          end
        end
        default: state_nx = INTEGRATE;
      endcase
    end
  end

  // State register; reset wins over a simultaneous enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INTEGRATE;
      cnt         <= '0;
      v_mem       <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      v_mem       <= v_nx;
      spike       <= spike_nx;
      spike_count <= count_nx;
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against an integer-arithmetic model.
module tb_lif_neuron;
  localparam int W = 18;
  localparam int VMAX = 131071;
  localparam int VMIN = -131072;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic signed [W-1:0] i_syn;
  logic                spike;
  logic signed [W-1:0] v_mem;
  logic                refractory;
  logic [15:0]         spike_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lif_neuron dut (
    .clock(clock), .reset(reset), .enable(enable), .i_syn(i_syn),
    .spike(spike), .v_mem(v_mem), .refractory(refractory), .spike_count(spike_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, floor division for the leak, ticks-left for refractory.
  int m_v = 0, m_left = 0, m_cnt = 0;
  bit m_spike = 0, mvalid = 0;

  function automatic int floor_div16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  // Model advances on every clock edge from the same inputs the DUT sees.
  always @(posedge clock) begin
    int nv;
    if (reset) begin
      m_v = 0; m_left = 0; m_cnt = 0; m_spike = 0; mvalid = 1;
    end else if (!enable) begin
      m_spike = 0;
    end else if (m_left > 0) begin
      m_left--; m_spike = 0; m_v = 0;
    end else begin
      nv = m_v + int'(i_syn) - floor_div16(m_v);
      if (nv > VMAX) nv = VMAX;
      if (nv < VMIN) nv = VMIN;
      if (nv >= 4096) begin
        m_v = 0; m_spike = 1; m_left = 8;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_v = nv; m_spike = 0;
      end
    end
  end

  // Compare all outputs to the model on the falling edge.
  always @(negedge clock) begin
    if (mvalid) begin
      chk("spike", spike, longint'(m_spike));
      chk("v_mem", v_mem, m_v);
      chk("refractory", refractory, longint'(m_left > 0));
      chk("spike_count", spike_count, m_cnt);
    end
  end

  // Apply inputs, then wait to the next falling edge (one rising edge in between).
  task automatic step(input logic r, input logic e, input int i);
    reset = r; enable = e; i_syn = W'(i);
    @(negedge clock);
  endtask

  initial begin
    int r, e, sel, x;
    // 1: reset beats simultaneous enable
    step(1, 1, 5000);
    chk("t1_v", v_mem, 0); chk("t1_spike", spike, 0);
    chk("t1_refr", refractory, 0); chk("t1_count", spike_count, 0);

    // 2: charge-up to the first spike
    step(0, 1, 1000); chk("t2_v1", v_mem, 1000);
    step(0, 1, 1000); chk("t2_v2", v_mem, 1938);
    step(0, 1, 1000); chk("t2_v3", v_mem, 2817);
    step(0, 1, 1000); chk("t2_v4", v_mem, 3641);
    step(0, 1, 1000);
    chk("t2_spike", spike, 1); chk("t2_v5", v_mem, 0);
    chk("t2_count", spike_count, 1); chk("t2_refr", refractory, 1);

    // 3: refractory with a 3-cycle enable gap, then immediate re-fire
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 131071); chk("t3_refr_a", refractory, 1); chk("t3_spike_a", spike, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 131071); chk("t3_refr_gap", refractory, 1);
    end
    for (int k = 4; k <= 7; k++) begin
      step(0, 1, 131071); chk("t3_refr_b", refractory, 1); chk("t3_v_b", v_mem, 0);
    end
    step(0, 1, 131071); chk("t3_refr_end", refractory, 0); chk("t3_spike_end", spike, 0);
    step(0, 1, 131071); chk("t3_refire", spike, 1); chk("t3_count", spike_count, 2);

    // 4: negative saturation
    step(1, 0, 0);
    step(0, 1, -131072); chk("t4_v1", v_mem, -131072);
    step(0, 1, -131072); chk("t4_v2", v_mem, -131072);
    step(0, 1, -131072); chk("t4_v3", v_mem, -131072); chk("t4_spike", spike, 0);

    // 5: enable low holds everything
    step(1, 0, 0);
    step(0, 1, 1000); step(0, 1, 1000);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 5000);
      chk("t5_v", v_mem, 1938); chk("t5_spike", spike, 0); chk("t5_count", spike_count, 0);
    end

    // 6: reset during the 4th refractory tick
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1000);
    chk("t6_fire", spike, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 1000);
    step(1, 1, 1000); chk("t6_refr", refractory, 0); chk("t6_v", v_mem, 0);
    step(0, 1, 1000); chk("t6_v_after", v_mem, 1000);

    // Threshold boundary: one below does not fire, exactly at it does
    step(1, 0, 0);
    step(0, 1, 4095); chk("thr_below", spike, 0); chk("thr_below_v", v_mem, 4095);
    step(1, 0, 0);
    step(0, 1, 4096); chk("thr_equal", spike, 1);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 149) == 0) ? 1 : 0;
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sel = $urandom_range(0, 5);
      case (sel)
        0: x = int'($signed(W'($urandom)));
        1: x = $urandom_range(0, 5000) - 2000;
        2: x = ($urandom_range(0, 1) == 1) ? VMAX : VMIN;
        default: x = $urandom_range(300, 1500);
      endcase
      step(r[0], e[0], x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
